// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: state encoding and default widths for mem_ctrl.
// Copy states exist only when MEM_CTRL_COPY_EN is defined.
package mem_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RSP,
    ST_WR
`ifdef MEM_CTRL_COPY_EN
    ,
    ST_CP_RD,
    ST_CP_WR
`endif
  } state_t;

endpackage

// File: rtl/mem_copy_seq.sv
// mem_copy_seq: word counter and src/dst address generator for the
// block-copy engine of mem_ctrl (built only with MEM_CTRL_COPY_EN).
module mem_copy_seq
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] src,
  input  logic [ADDR_WIDTH-1:0] dst,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic [ADDR_WIDTH-1:0] rd_next,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ONE =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      idx   <= '0;
    end else if (load) begin
      src_q <= src;
      dst_q <= dst;
      len_q <= len;
      idx   <= '0;
    end else if (step) begin
      idx <= idx + ONE;
    end
  end

  // Sums wrap naturally at ADDR_WIDTH bits.
  assign rd_next = src_q + idx + ONE;
  assign wr_addr = dst_q + idx;
  assign last    = (idx == len_q - ONE);

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-port memory controller with load/store handshake.
// Define MEM_CTRL_COPY_EN to add the block-copy engine.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_out,
`ifdef MEM_CTRL_COPY_EN
  input  logic                  copy_start,
  input  logic [ADDR_WIDTH-1:0] copy_src,
  input  logic [ADDR_WIDTH-1:0] copy_dst,
  input  logic [ADDR_WIDTH-1:0] copy_len,
  output logic                  copy_done,
`endif
  output logic                  busy
);

  state_t state;
  state_t state_d;

  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  write_d;
  logic                  rvalid_d;

`ifdef MEM_CTRL_COPY_EN
  logic                  done_d;
  logic                  cp_load;
  logic                  cp_step;
  logic                  cp_last;
  logic [ADDR_WIDTH-1:0] cp_rd_next;
  logic [ADDR_WIDTH-1:0] cp_wr_addr;

  mem_copy_seq #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cp_load),
    .step    (cp_step),
    .src     (copy_src),
    .dst     (copy_dst),
    .len     (copy_len),
    .rd_next (cp_rd_next),
    .wr_addr (cp_wr_addr),
    .last    (cp_last)
  );

  assign req_ready = (state == ST_IDLE) && !copy_start;
`else
  assign req_ready = (state == ST_IDLE);
`endif

  assign busy = (state != ST_IDLE);

  always_comb begin
    state_d  = state;
    addr_d   = mem_addr;
    data_d   = mem_data;
    write_d  = 1'b0;
    rvalid_d = rsp_valid;
    rdata_d  = rsp_rdata;
`ifdef MEM_CTRL_COPY_EN
    done_d   = 1'b0;
    cp_load  = 1'b0;
    cp_step  = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
`ifdef MEM_CTRL_COPY_EN
        if (copy_start) begin
          if (copy_len == '0) begin
            done_d = 1'b1;
          end else begin
            cp_load = 1'b1;
            addr_d  = copy_src;
            state_d = ST_CP_RD;
          end
        end else
`endif
        if (req_valid) begin
          addr_d = req_addr;
          if (req_write) begin
            data_d  = req_wdata;
            write_d = 1'b1;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      // Memory latched the address on the falling edge; word is valid now.
      ST_RD: begin
        rvalid_d = 1'b1;
        rdata_d  = mem_out;
        state_d  = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
`ifdef MEM_CTRL_COPY_EN
      ST_CP_RD: begin
        addr_d  = cp_wr_addr;
        data_d  = mem_out;
        write_d = 1'b1;
        state_d = ST_CP_WR;
      end
      ST_CP_WR: begin
        cp_step = 1'b1;
        if (cp_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = cp_rd_next;
          state_d = ST_CP_RD;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_CTRL_COPY_EN
      copy_done <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      mem_addr  <= addr_d;
      mem_data  <= data_d;
      mem_write <= write_d;
      rsp_valid <= rvalid_d;
      rsp_rdata <= rdata_d;
`ifdef MEM_CTRL_COPY_EN
      copy_done <= done_d;
`endif
    end
  end

endmodule
